// File: rtl/miss_msg_det_mc.sv
// Multi-channel MoldUDP64 missed-message detector with a gap-report FIFO.
// Optional macro MISS_MSG_DET_MC_LEARN_EN: learn SID/sequence from the first packet per channel.
module miss_msg_det_mc #(
  parameter int unsigned CH_N        = 4,
  parameter int unsigned CH_W        = $clog2(CH_N),
  parameter int unsigned SEQ_NUM_W   = 64,
  parameter int unsigned SID_W       = 80,
  parameter int unsigned ML_W        = 16,
  parameter int unsigned SID_GAP_MAX = 1 << 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 v_i,
  input  logic [CH_W-1:0]      ch_i,
  input  logic [SID_W-1:0]     sid_i,
  input  logic [SEQ_NUM_W-1:0] seq_num_i,
  input  logic [ML_W-1:0]      msg_cnt_i,
  input  logic                 eos_i,
  output logic                 gap_v_o,
  input  logic                 gap_ready_i,
  output logic [CH_W-1:0]      gap_ch_o,
  output logic                 gap_type_o,
  output logic [SID_W-1:0]     gap_sid_o,
  output logic [SEQ_NUM_W-1:0] gap_seq_start_o,
  output logic [SEQ_NUM_W-1:0] gap_seq_cnt_o,
  output logic [SID_W-1:0]     gap_sid_cnt_o,
  output logic                 ovf_o,
  output logic [15:0]          drop_cnt_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [CH_W-1:0]      ch;
    logic                 typ;
    logic [SID_W-1:0]     sid;
    logic [SEQ_NUM_W-1:0] seq_start;
    logic [SEQ_NUM_W-1:0] seq_cnt;
    logic [SID_W-1:0]     sid_cnt;
  } rec_t;

  logic [SID_W-1:0]     r_sid [CH_N];
  logic [SEQ_NUM_W-1:0] r_exp [CH_N];
  logic [CH_N-1:0]      r_eos;
`ifdef MISS_MSG_DET_MC_LEARN_EN
  logic [CH_N-1:0]      r_learned;
`endif

  logic                 w_ch_ok;
  logic [SID_W-1:0]     w_cur_sid;
  logic [SEQ_NUM_W-1:0] w_cur_exp;
  logic                 w_cur_eos;
  logic [SEQ_NUM_W:0]   w_sum;
  logic                 w_carry;
  logic [SEQ_NUM_W-1:0] w_sum_clamp;
  logic [SID_W-1:0]     w_sid_diff;
  logic                 w_upd;
  logic [SID_W-1:0]     w_nxt_sid;
  logic [SEQ_NUM_W-1:0] w_nxt_exp;
  logic                 w_nxt_eos;
  logic                 w_push;
  rec_t                 w_rec;

  assign w_ch_ok     = ({1'b0, ch_i} <= (CH_W+1)'(CH_N - 1));
  assign w_cur_sid   = r_sid[ch_i];
  assign w_cur_exp   = r_exp[ch_i];
  assign w_cur_eos   = r_eos[ch_i];
  assign w_sum       = {1'b0, seq_num_i} + (SEQ_NUM_W+1)'(msg_cnt_i);
  assign w_carry     = w_sum[SEQ_NUM_W];
  // A carried sum pins exp at all-ones and marks the session as ended
  assign w_sum_clamp = w_carry ? '1 : w_sum[SEQ_NUM_W-1:0];
  assign w_sid_diff  = sid_i - w_cur_sid;

  // Per-packet classification for the addressed channel
  always_comb begin
    w_upd     = 1'b0;
    w_nxt_sid = w_cur_sid;
    w_nxt_exp = w_cur_exp;
    w_nxt_eos = w_cur_eos;
    w_push    = 1'b0;
    w_rec     = '0;
    if (v_i && w_ch_ok) begin
`ifdef MISS_MSG_DET_MC_LEARN_EN
      if (!r_learned[ch_i]) begin
        w_upd     = 1'b1;
        w_nxt_sid = sid_i;
        w_nxt_exp = w_sum_clamp;
        w_nxt_eos = eos_i | w_carry;
      end else
`endif
      if (sid_i == w_cur_sid) begin
        if ((seq_num_i >= w_cur_exp) || (w_sum > {1'b0, w_cur_exp})) begin
          w_upd     = 1'b1;
          w_nxt_exp = w_sum_clamp;
          w_nxt_eos = w_cur_eos | eos_i | w_carry;
        end
        if (seq_num_i > w_cur_exp) begin
          w_push          = 1'b1;
          w_rec.ch        = ch_i;
          w_rec.typ       = 1'b0;
          w_rec.sid       = w_cur_sid;
          w_rec.seq_start = w_cur_exp;
          w_rec.seq_cnt   = seq_num_i - w_cur_exp;
        end
      end else if (sid_i > w_cur_sid) begin
        w_upd     = 1'b1;
        w_nxt_sid = sid_i;
        w_nxt_exp = w_sum_clamp;
        w_nxt_eos = 1'b0;
        if ((w_sid_diff < SID_W'(SID_GAP_MAX)) &&
            !((w_sid_diff == SID_W'(1)) && w_cur_eos && (seq_num_i == '0))) begin
          w_push          = 1'b1;
          w_rec.ch        = ch_i;
          w_rec.typ       = 1'b1;
          w_rec.sid       = w_cur_sid;
          w_rec.seq_start = w_cur_exp;
          w_rec.seq_cnt   = seq_num_i;
          w_rec.sid_cnt   = w_sid_diff;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < int'(CH_N); i++) begin
        r_sid[i] <= '0;
        r_exp[i] <= '0;
      end
      r_eos <= '0;
`ifdef MISS_MSG_DET_MC_LEARN_EN
      r_learned <= '0;
`endif
    end else if (w_upd) begin
      r_sid[ch_i] <= w_nxt_sid;
      r_exp[ch_i] <= w_nxt_exp;
      r_eos[ch_i] <= w_nxt_eos;
`ifdef MISS_MSG_DET_MC_LEARN_EN
      r_learned[ch_i] <= 1'b1;
`endif
    end
  end

  // Report FIFO
  rec_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [15:0]      r_drop_cnt;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  rec_t             w_head;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full    = (r_cnt == CNT_W'(FIFO_DEPTH));
  assign w_pop     = (r_cnt != '0) && gap_ready_i;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_rec;
        r_wr_ptr        <= f_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign gap_v_o         = (r_cnt != '0);
  assign gap_ch_o        = w_head.ch;
  assign gap_type_o      = w_head.typ;
  assign gap_sid_o       = w_head.sid;
  assign gap_seq_start_o = w_head.seq_start;
  assign gap_seq_cnt_o   = w_head.seq_cnt;
  assign gap_sid_cnt_o   = w_head.sid_cnt;
  assign ovf_o           = r_ovf;
  assign drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_miss_msg_det_mc.sv
// Bench for miss_msg_det_mc: directed scenarios plus randomized traffic against a
// queue-based behavioural model of the per-channel rules and the report FIFO.
module tb_miss_msg_det_mc;

  localparam int DEPTH = 4;
  localparam logic [79:0] SGM = 80'd65536;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        v_i = 1'b0;
  logic [1:0]  ch_i = '0;
  logic [79:0] sid_i = '0;
  logic [63:0] seq_num_i = '0;
  logic [15:0] msg_cnt_i = '0;
  logic        eos_i = 1'b0;
  logic        gap_v_o;
  logic        gap_ready_i = 1'b0;
  logic [1:0]  gap_ch_o;
  logic        gap_type_o;
  logic [79:0] gap_sid_o;
  logic [63:0] gap_seq_start_o;
  logic [63:0] gap_seq_cnt_o;
  logic [79:0] gap_sid_cnt_o;
  logic        ovf_o;
  logic [15:0] drop_cnt_o;

  miss_msg_det_mc dut (
    .clk(clk), .nreset(nreset), .v_i(v_i), .ch_i(ch_i), .sid_i(sid_i),
    .seq_num_i(seq_num_i), .msg_cnt_i(msg_cnt_i), .eos_i(eos_i),
    .gap_v_o(gap_v_o), .gap_ready_i(gap_ready_i), .gap_ch_o(gap_ch_o),
    .gap_type_o(gap_type_o), .gap_sid_o(gap_sid_o), .gap_seq_start_o(gap_seq_start_o),
    .gap_seq_cnt_o(gap_seq_cnt_o), .gap_sid_cnt_o(gap_sid_cnt_o),
    .ovf_o(ovf_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  typedef struct {
    int          ch;
    bit          typ;
    logic [79:0] sid;
    logic [63:0] start;
    logic [63:0] scnt;
    logic [79:0] sidcnt;
  } trec_t;

  trec_t       mq[$];
  logic [79:0] m_sid [4];
  logic [63:0] m_exp [4];
  bit          m_eos [4];
  bit          m_lrn [4];
  bit          m_ovf;
  int          m_drop;

  function automatic void model_pkt(input int c, input logic [79:0] s, input logic [63:0] q,
                                    input logic [15:0] n, input bit e,
                                    output bit push, output trec_t r);
    logic [64:0] sum;
    logic [63:0] nexp;
    logic [79:0] d;
    bit last;
    sum  = {1'b0, q} + {49'd0, n};
    last = sum[64];
    nexp = last ? 64'hFFFF_FFFF_FFFF_FFFF : sum[63:0];
    d    = s - m_sid[c];
    push = 1'b0;
    r.ch = c; r.typ = 1'b0; r.sid = m_sid[c]; r.start = m_exp[c]; r.scnt = '0; r.sidcnt = '0;
`ifdef MISS_MSG_DET_MC_LEARN_EN
    if (!m_lrn[c]) begin
      m_lrn[c] = 1'b1; m_sid[c] = s; m_exp[c] = nexp; m_eos[c] = e | last;
      return;
    end
`endif
    if (s < m_sid[c]) return;
    if (s == m_sid[c]) begin
      if (q > m_exp[c]) begin
        push = 1'b1; r.scnt = q - m_exp[c];
      end
      if (q >= m_exp[c] || sum > {1'b0, m_exp[c]}) begin
        m_exp[c] = nexp;
        if (e || last) m_eos[c] = 1'b1;
      end
      return;
    end
    if (d < SGM && !(d == 80'd1 && m_eos[c] && q == 64'd0)) begin
      push = 1'b1; r.typ = 1'b1; r.scnt = q; r.sidcnt = d;
    end
    m_sid[c] = s; m_exp[c] = nexp; m_eos[c] = 1'b0;
  endfunction

  always @(posedge clk or negedge nreset) begin
    bit    pop_now;
    bit    have;
    trec_t r;
    if (!nreset) begin
      for (int i = 0; i < 4; i++) begin
        m_sid[i] = '0; m_exp[i] = '0; m_eos[i] = 1'b0; m_lrn[i] = 1'b0;
      end
      mq.delete(); m_ovf = 1'b0; m_drop = 0;
    end else begin
      pop_now = (mq.size() > 0) && gap_ready_i;
      have = 1'b0;
      if (v_i) model_pkt(int'(ch_i), sid_i, seq_num_i, msg_cnt_i, eos_i, have, r);
      if (have) begin
        if (mq.size() >= DEPTH && !pop_now) begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end else mq.push_back(r);
      end
      if (pop_now) void'(mq.pop_front());
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (nreset) begin
      chk("cmp_v", 80'(gap_v_o), 80'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("cmp_ch", 80'(gap_ch_o), 80'(mq[0].ch));
        chk("cmp_type", 80'(gap_type_o), 80'(mq[0].typ));
        chk("cmp_sid", gap_sid_o, mq[0].sid);
        chk("cmp_start", 80'(gap_seq_start_o), 80'(mq[0].start));
        chk("cmp_scnt", 80'(gap_seq_cnt_o), 80'(mq[0].scnt));
        chk("cmp_sidcnt", gap_sid_cnt_o, mq[0].sidcnt);
      end
      chk("cmp_ovf", 80'(ovf_o), 80'(m_ovf));
      chk("cmp_drop", 80'(drop_cnt_o), 80'(m_drop));
    end
  end

  task automatic send(input int c, input logic [79:0] s, input logic [63:0] q,
                      input logic [15:0] n, input bit e);
    v_i = 1'b1; ch_i = 2'(c); sid_i = s; seq_num_i = q; msg_cnt_i = n; eos_i = e;
    @(posedge clk); #1;
    v_i = 1'b0; eos_i = 1'b0;
  endtask

  task automatic drain();
    gap_ready_i = 1'b1;
    for (int k = 0; k < 20 && mq.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    if (mq.size() != 0) chk("drain_timeout", 80'(mq.size()), 80'd0);
    gap_ready_i = 1'b0;
  endtask

  int          c, m;
  logic [79:0] s;
  logic [63:0] q;
  logic [15:0] n;
  bit          e;

  initial begin
    #2;
    chk("rst_v", 80'(gap_v_o), 80'd0);
    chk("rst_ovf", 80'(ovf_o), 80'd0);
    chk("rst_drop", 80'(drop_cnt_o), 80'd0);
    chk("rst_start", 80'(gap_seq_start_o), 80'd0);
    chk("rst_sid", gap_sid_o, 80'd0);
    #10 nreset = 1'b1;
    @(posedge clk); #1;

    // In-order packets on ch0
    send(0, 80'd0, 64'd0, 16'd5, 1'b0);
    send(0, 80'd0, 64'd5, 16'd3, 1'b0);
    chk("s1_v", 80'(gap_v_o), 80'd0);
    chk("s1_exp0", 80'(m_exp[0]), 80'd8);

    // Sequence gap on ch1
    send(1, 80'd0, 64'd0, 16'd8, 1'b0);
    send(1, 80'd0, 64'd12, 16'd2, 1'b0);
    chk("s2_v", 80'(gap_v_o), 80'd1);
    chk("s2_ch", 80'(gap_ch_o), 80'd1);
    chk("s2_type", 80'(gap_type_o), 80'd0);
    chk("s2_start", 80'(gap_seq_start_o), 80'd8);
    chk("s2_cnt", 80'(gap_seq_cnt_o), 80'd4);
    chk("s2_exp1", 80'(m_exp[1]), 80'd14);
    drain();

    // Clean rollover on ch2, session gap on ch3
    send(2, 80'd0, 64'd0, 16'd10, 1'b0);
    send(2, 80'd0, 64'd10, 16'd0, 1'b1);
    send(2, 80'd1, 64'd0, 16'd3, 1'b0);
    chk("s3_roll_v", 80'(gap_v_o), 80'd0);
    send(3, 80'd0, 64'd0, 16'd4, 1'b0);
    send(3, 80'd3, 64'd7, 16'd2, 1'b0);
    chk("s3_v", 80'(gap_v_o), 80'd1);
    chk("s3_type", 80'(gap_type_o), 80'd1);
    chk("s3_sid", gap_sid_o, 80'd0);
    chk("s3_sidcnt", gap_sid_cnt_o, 80'd3);
    chk("s3_scnt", 80'(gap_seq_cnt_o), 80'd7);
    chk("s3_start", 80'(gap_seq_start_o), 80'd4);
    drain();

    // Duplicate extends exp; stale SID ignored
    send(0, 80'd0, 64'd6, 16'd4, 1'b0);
    chk("s4_exp0", 80'(m_exp[0]), 80'd10);
    send(2, 80'd0, 64'd50, 16'd1, 1'b0);
    chk("s4_v", 80'(gap_v_o), 80'd0);
    chk("s4_sid2", m_sid[2], 80'd1);
    chk("s4_exp2", 80'(m_exp[2]), 80'd3);

    // Five gaps into a stalled FIFO of four
    for (int k = 0; k < 5; k++) send(0, 80'd0, 64'(12 + 3 * k), 16'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("s5_head", 80'(gap_seq_start_o), 80'd10);
    chk("s5_ovf", 80'(ovf_o), 80'd1);
    chk("s5_drop", 80'(drop_cnt_o), 80'd1);
    gap_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("s5_order", 80'(gap_seq_start_o), 80'(10 + 3 * k));
      @(posedge clk); #1;
    end
    chk("s5_empty", 80'(gap_v_o), 80'd0);
    gap_ready_i = 1'b0;

    // Reset with two records pending
    send(0, 80'd0, 64'd27, 16'd1, 1'b0);
    send(0, 80'd0, 64'd30, 16'd1, 1'b0);
    chk("s6_pre", 80'(gap_v_o), 80'd1);
    #2 nreset = 1'b0;
    #1;
    chk("s6_v", 80'(gap_v_o), 80'd0);
    chk("s6_ovf", 80'(ovf_o), 80'd0);
    chk("s6_drop", 80'(drop_cnt_o), 80'd0);
    chk("s6_start", 80'(gap_seq_start_o), 80'd0);
    @(posedge clk); #3 nreset = 1'b1;
    @(posedge clk); #1;
    send(1, 80'd42, 64'd900, 16'd7, 1'b0);
`ifdef MISS_MSG_DET_MC_LEARN_EN
    chk("s6_learn_v", 80'(gap_v_o), 80'd0);
    chk("s6_learn_exp", 80'(m_exp[1]), 80'd907);
`else
    chk("s6_v2", 80'(gap_v_o), 80'd1);
    chk("s6_type", 80'(gap_type_o), 80'd1);
    chk("s6_sidcnt", gap_sid_cnt_o, 80'd42);
    chk("s6_scnt", 80'(gap_seq_cnt_o), 80'd900);
    chk("s6_start2", 80'(gap_seq_start_o), 80'd0);
`endif
    drain();

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      gap_ready_i = ((cyc / 256) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      if (cyc == 2000) begin
        #2 nreset = 1'b0;
        @(posedge clk); #3 nreset = 1'b1;
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 9) < 7) begin
        c = $urandom_range(0, 3);
        s = m_sid[c]; q = m_exp[c]; n = 16'($urandom_range(0, 10)); e = 1'b0;
        m = $urandom_range(0, 99);
        if (m < 50) e = ($urandom_range(0, 9) == 0);
        else if (m < 65) begin q = m_exp[c] + 64'($urandom_range(1, 20)); e = ($urandom_range(0, 9) == 0); end
        else if (m < 75) q = m_exp[c] - 64'($urandom_range(0, 5));
        else if (m < 78) begin q = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)); n = 16'($urandom_range(0, 40)); end
        else if (m < 85) begin s = m_sid[c] + 80'd1; q = '0; end
        else if (m < 92) begin s = m_sid[c] + 80'($urandom_range(1, 5)); q = 64'($urandom_range(0, 50)); end
        else if (m < 96) begin s = m_sid[c] + 80'd65535 + 80'($urandom_range(0, 2)); q = 64'($urandom_range(0, 1000)); end
        else if (m_sid[c] != '0) s = m_sid[c] - 80'd1;
        send(c, s, q, n, e);
      end else begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
